// File: rtl/hs_io_pkg.sv
// rtl/hs_io_pkg.sv - shared types and constants for the handshake I/O device
package hs_io_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_e;

    localparam int HS_DATA_W          = 8;
    localparam int HS_DEFAULT_DEPTH   = 4;
    localparam int HS_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - circular FIFO with push/pop/full/empty/count, no bypass
module hs_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Refused operations are filtered here so callers may strobe freely.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hs_io_device.sv
// rtl/hs_io_device.sv - four-phase handshake peripheral with RX/TX FIFOs; option HS_IO_REQ_SYNC_EN
module hs_io_device
    import hs_io_pkg::*;
#(
    parameter int DEPTH   = HS_DEFAULT_DEPTH,
    parameter int TIMEOUT = HS_DEFAULT_TIMEOUT
) (
    input  logic                    g_clk,
    input  logic                    g_clr,
    input  logic [HS_DATA_W-1:0]    cpu_data_in,
    input  logic                    cpu_req,
    input  logic                    cpu_rd,
    output logic [HS_DATA_W-1:0]    cpu_data_out,
    output logic                    cpu_ack,
    input  logic [HS_DATA_W-1:0]    tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [HS_DATA_W-1:0]    rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic                    stall_err,
    input  logic                    err_clr
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    hs_state_e            state_q;
    logic                 ack_q;
    logic [HS_DATA_W-1:0] data_out_q;
    logic [7:0]           stall_cnt_q;
    logic [7:0]           stall_cnt_d;
    logic                 stall_err_q;
    logic                 stall_err_d;

    logic                 req_eff;
    logic                 rx_push;
    logic                 tx_pop;
    logic                 stalled;
    logic                 err_set;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 tx_full;
    logic                 tx_empty;
    logic [HS_DATA_W-1:0] tx_head;

`ifdef HS_IO_REQ_SYNC_EN
    logic req_s1_q;
    logic req_s2_q;

    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
        end else begin
            req_s1_q <= cpu_req;
            req_s2_q <= req_s1_q;
        end
    end

    assign req_eff = req_s2_q;
`else
    assign req_eff = cpu_req;
`endif

    hs_fifo #(
        .WIDTH (HS_DATA_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (g_clk),
        .resetn    (g_clr),
        .push      (rx_push),
        .push_data (cpu_data_in),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    hs_fifo #(
        .WIDTH (HS_DATA_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (g_clk),
        .resetn    (g_clr),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    always_comb begin
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        stalled = 1'b0;
        if (state_q == IDLE && req_eff) begin
            if (!cpu_rd) begin
                rx_push = !rx_full;
                stalled = rx_full;
            end else begin
                tx_pop  = !tx_empty;
                stalled = tx_empty;
            end
        end
    end

    // Counter saturates; a stall that persists keeps re-asserting the error.
    always_comb begin
        stall_cnt_d = 8'h00;
        if (stalled) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'h01;
        end
        err_set     = stalled && (stall_cnt_d >= TIMEOUT_LIM);
        stall_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : stall_err_q);
    end

    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            data_out_q  <= '0;
            stall_cnt_q <= 8'h00;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            case (state_q)
                IDLE: begin
                    if (rx_push || tx_pop) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        if (tx_pop) begin
                            data_out_q <= tx_head;
                        end
                    end
                end
                ACK: begin
                    // One transfer per request: wait here until req is released.
                    if (!req_eff) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack      = ack_q;
    assign cpu_data_out = data_out_q;
    assign stall_err    = stall_err_q;

endmodule

// File: doc/hs_io_device.md
Name: hs_io_device

Overview:
- Far-end peripheral for the processor's 8-bit handshake I/O port.
- Answers the processor's hs_out requests with hs_in acknowledges, on a four-phase protocol.
- OUT transfers (processor → device) are captured into an RX FIFO that a host drains.
- IN transfers (device → processor) are served from a TX FIFO that a host fills; the device drives the processor's bus_in.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- TIMEOUT, 255, cycles a request may stall on a full or empty FIFO before the sticky error flag is set; 8-bit counter.

Ports:
- g_clk  in  1  clock; all logic on its rising edge.
- g_clr  in  1  synchronous active-low reset.
- cpu_data_in  in  8  processor bus_out; valid while cpu_req=1 and cpu_rd=0.
- cpu_req  in  1  processor hs_out; transfer request.
- cpu_rd  in  1  1 = IN transfer (processor reads), 0 = OUT transfer; stable while cpu_req=1.
- cpu_data_out  out  8  to processor bus_in; registered.
- cpu_ack  out  1  to processor hs_in; registered.
- tx_data  in  8  host byte for the processor to read.
- tx_valid  in  1  host push strobe.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of RX FIFO; combinational from storage.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host pop strobe.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.
- stall_err  out  1  sticky timeout flag.
- err_clr  in  1  clears stall_err.

Behaviour:
- Reset (g_clr=0 at an edge):
  - cpu_ack=0, cpu_data_out=8'h00, stall_err=0.
  - Both FIFOs empty: counts 0, rx_valid=0, tx_ready=1.
  - FSM goes to IDLE and the stall counter goes to 0.
  - Reset wins over every other event. An in-progress handshake is abandoned: ack drops and no push or pop completes.
- FSM states: IDLE, ACK.
- IDLE:
  - When cpu_req=1, cpu_rd=0 and RX is not full: push cpu_data_in, set cpu_ack=1, go to ACK.
  - When cpu_req=1, cpu_rd=1 and TX is not empty: pop TX into cpu_data_out, set cpu_ack=1, go to ACK.
  - When cpu_req=1 and the FIFO is full (OUT) or empty (IN): stay in IDLE with ack=0 and increment the stall counter.
  - The stall counter saturates. Reaching TIMEOUT sets stall_err.
  - The counter clears whenever cpu_req=0 or a transfer is accepted.
- ACK:
  - Hold cpu_ack=1 and cpu_data_out stable.
  - When cpu_req=0: cpu_ack=0, go to IDLE.
  - Each request completes exactly one transfer, however long cpu_req stays high.
- Latency: with cpu_req sampled high at edge N, cpu_ack is high after edge N (one-cycle registered response). After req drops, ack falls one edge after req is first sampled low.
- FIFOs:
  - Circular buffers with pointer wrap modulo DEPTH.
  - Push when full is ignored; tx_ready=0 prevents it.
  - Pop when empty is ignored.
  - Simultaneous push and pop in the same cycle is allowed at any occupancy except: push to a full FIFO is still refused, and pop from an empty FIFO is still refused.
  - No bypass: a byte pushed at edge N is poppable from edge N+1.
- Priority: err_clr and a same-cycle timeout together leave stall_err=1 (set wins).
- cpu_data_out retains its last value after ACK ends.

Optional Feature:
- HS_IO_REQ_SYNC_EN
  - Defined: cpu_req passes through a 2-flop synchronizer before the FSM, for use with an asynchronous processor clock.
    - Ack latency becomes 3 edges; release latency becomes 3 edges.
    - Synchronizer flops reset to 0.
    - cpu_data_in and cpu_rd are sampled at the same edge the synchronized req is acted on; they must be stable ≥3 cycles before req rises.
  - Undefined: cpu_req is used directly, with the latencies above.

Decomposition:
- Package hs_io_pkg holds:
  - FSM state typedef (IDLE=1'b0, ACK=1'b1).
  - Data-width constant (8).
  - Default DEPTH and TIMEOUT constants.
- One sub-module, hs_fifo: parameterised width/depth circular FIFO with push/pop/full/empty/count. Instantiated twice (RX, TX).

Test Plan:
- OUT write: reset, cpu_rd=0, cpu_data_in=8'hA5, cpu_req=1 → cpu_ack=1 after the first edge, rx_valid=1, rx_data=8'hA5, rx_count=1. Drop req → ack=0 after the next edge; rx_count stays 1.
- IN read: host pushes 8'h3C then 8'h7E. Two IN handshakes → cpu_data_out=8'h3C during the first ack, 8'h7E during the second; tx_count ends at 0.
- IN stall: TX empty, cpu_rd=1, req held → ack stays 0. Host pushes 8'h11 at cycle 5 → ack high the edge after the push becomes visible (cycle 7), cpu_data_out=8'h11.
- Full/timeout with TIMEOUT=3: fill RX with 4 OUT writes (8'h01..8'h04), issue a 5th with req held → no ack, stall_err=1 after the 3rd stalled cycle. Host pops 1 → 5th write accepted, rx_count=4, stall_err stays 1. err_clr → stall_err=0.
- Wrap and simultaneity: 10 OUT writes 8'h00..8'h09 with the host popping every accepted byte in the same cycle as the next push → all 10 bytes popped in order, no loss, rx_count never exceeds 1.
- Reset mid-handshake: during ACK of an IN transfer, drive g_clr=0 for one edge → cpu_ack=0, cpu_data_out=8'h00, counts 0. cpu_req still high after reset → a new transfer starts only if a FIFO permits.
